clock_phase_gen: RTL and testbench

CLOCK_PHASE_GEN -- requirements
Module: clock_phase_gen

---
 rtl/clock_phase_gen.sv | 113 +++++++++++
 tb/tb_clock_phase_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_phase_gen.sv
// Quarter-phase clock divider: four phases of (clk_div+1) cycles each, clk_o high in phases 2/3.
// Supports high-phase stretching and glitch-free divisor updates deferred to the period boundary.
module clock_phase_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int RESET_DIV = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [DIV_WIDTH-1:0] set_clk_div,
  input  logic                 div_update,
  input  logic                 stretch_i,
  output logic [DIV_WIDTH-1:0] clk_div,
  output logic                 div_pending,
  output logic                 clk_o,
  output logic [1:0]           phase_o,
  output logic                 tick_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  localparam logic [DIV_WIDTH-1:0] RST_DIV = DIV_WIDTH'(RESET_DIV);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                 pend_q, pend_d;
  logic [1:0]           phase_q, phase_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 hold, adv;

  assign hold = stretch_i && (phase_q == 2'd2);
  assign adv  = !hold && (cnt_q == div_q);

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    phase_d    = phase_q;
    clk_d      = clk_q;
    tick_d     = 1'b0;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    if (!clk_en) begin
      div_d   = set_clk_div;
      cnt_d   = '0;
      phase_d = 2'd0;
      clk_d   = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (div_update) begin
        pend_val_d = set_clk_div;
        pend_d     = 1'b1;
      end
      if (adv) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
        tick_d  = 1'b1;
        if (phase_q == 2'd1) begin
          clk_d  = 1'b1;
          rise_d = 1'b1;
        end
        // Divisor only changes here, where cnt restarts at 0, so no phase is ever cut short.
        if (phase_q == 2'd3) begin
          clk_d  = 1'b0;
          fall_d = 1'b1;
          pend_d = 1'b0;
          if (div_update)  div_d = set_clk_div;
          else if (pend_q) div_d = pend_val_q;
        end
      end else if (!hold) begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      div_q      <= RST_DIV;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      phase_q    <= 2'd0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign clk_div     = div_q;
  assign div_pending = pend_q;
  assign clk_o       = clk_q;
  assign phase_o     = phase_q;
  assign tick_o      = tick_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Bench for clock_phase_gen: per-cycle scoreboard against a cycle model plus directed timing checks.
module tb_clock_phase_gen;
  localparam int DW = 8;
  localparam int RD = 5;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic [DW-1:0] set_clk_div = RD[DW-1:0];
  logic          div_update = 1'b0;
  logic          stretch_i = 1'b0;
  logic [DW-1:0] clk_div;
  logic          div_pending, clk_o, tick_o, rise_o, fall_o;
  logic [1:0]    phase_o;

  clock_phase_gen #(.DIV_WIDTH(DW), .RESET_DIV(RD)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .clk_en(clk_en), .set_clk_div(set_clk_div),
    .div_update(div_update), .stretch_i(stretch_i), .clk_div(clk_div),
    .div_pending(div_pending), .clk_o(clk_o), .phase_o(phase_o),
    .tick_o(tick_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int div, pend, clk, ph, tick, rise, fall;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_err = 0;
  int m_cnt, m_ph, m_clk, m_tick, m_rise, m_fall, m_div, m_pend, m_pval;
  int cyc = 0, rise_at = 0, fall_at = 0, ticks = 0, rises = 0, falls = 0;
  int f0, f1, r0, i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_clk = 0; m_tick = 0; m_rise = 0; m_fall = 0;
    m_div = RD; m_pend = 0; m_pval = 0;
  endtask

  task automatic model_next();
    bit held;
    m_tick = 0; m_rise = 0; m_fall = 0;
    if (!clk_en) begin
      m_div = int'(set_clk_div); m_cnt = 0; m_ph = 0; m_clk = 0; m_pend = 0;
    end else begin
      held = stretch_i && (m_ph == 2);
      if (!held && m_cnt == m_div) begin
        m_cnt = 0;
        m_tick = 1;
        if (m_ph == 3) begin
          m_ph = 0; m_clk = 0; m_fall = 1;
          if (div_update) m_div = int'(set_clk_div);
          else if (m_pend != 0) m_div = m_pval;
          m_pend = 0;
        end else begin
          m_ph = m_ph + 1;
          if (m_ph == 2) begin m_clk = 1; m_rise = 1; end
          if (div_update) begin m_pval = int'(set_clk_div); m_pend = 1; end
        end
      end else begin
        if (!held) m_cnt = m_cnt + 1;
        if (div_update) begin m_pval = int'(set_clk_div); m_pend = 1; end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    model_next();
    e = '{m_div, m_pend, m_clk, m_ph, m_tick, m_rise, m_fall};
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("clk_div", 32'(clk_div), e.div);
    chk("div_pending", 32'(div_pending), e.pend);
    chk("clk_o", 32'(clk_o), e.clk);
    chk("phase_o", 32'(phase_o), e.ph);
    chk("tick_o", 32'(tick_o), e.tick);
    chk("rise_o", 32'(rise_o), e.rise);
    chk("fall_o", 32'(fall_o), e.fall);
    if (tick_o) ticks++;
    if (rise_o) begin rises++; rise_at = cyc; end
    if (fall_o) begin falls++; fall_at = cyc; end
  endtask

  task automatic wait_rise();
    int n = 0;
    do begin step(); n++; end while (!rise_o && n < 80);
    chk("wait_rise", 32'(rise_o), 1);
  endtask

  task automatic wait_fall();
    int n = 0;
    do begin step(); n++; end while (!fall_o && n < 80);
    chk("wait_fall", 32'(fall_o), 1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_clk_div", 32'(clk_div), RD);
    chk("rst_outs", {26'd0, div_pending, clk_o, phase_o, tick_o, rise_o, fall_o}, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // divisor 0: period 4, tick every cycle
    set_clk_div = 8'd0;
    step();
    clk_en = 1'b1;
    ticks = 0; rises = 0; falls = 0;
    repeat (12) step();
    chk("div0_ticks", ticks, 12);
    chk("div0_rises", rises, 3);
    chk("div0_falls", falls, 3);

    // divisor 3: rise after 8th enabled edge, fall after 16th
    clk_en = 1'b0; set_clk_div = 8'd3;
    step();
    clk_en = 1'b1;
    cyc = 0; ticks = 0; rise_at = 0; fall_at = 0;
    repeat (16) step();
    chk("div3_rise_edge", rise_at, 8);
    chk("div3_fall_edge", fall_at, 16);
    chk("div3_ticks", ticks, 4);

    // stretch 10 cycles at start of phase 2
    wait_rise();
    r0 = rise_at;
    stretch_i = 1'b1;
    ticks = 0;
    repeat (10) step();
    chk("stretch_no_tick", ticks, 0);
    stretch_i = 1'b0;
    wait_fall();
    chk("stretch_high", fall_at - r0, 18);
    wait_rise();
    chk("stretch_period", rise_at - r0, 26);

    // stretch in phase 0 is ignored
    wait_fall();
    f0 = fall_at;
    stretch_i = 1'b1;
    wait_rise();
    chk("stretch_ph0", rise_at - f0, 8);
    stretch_i = 1'b0;

    // deferred divisor update issued in phase 1
    wait_fall();
    f0 = fall_at;
    repeat (4) step();
    chk("upd_ph1", 32'(phase_o), 1);
    set_clk_div = 8'd1; div_update = 1'b1;
    step();
    div_update = 1'b0; set_clk_div = 8'd7;
    chk("upd_pending", 32'(div_pending), 1);
    chk("upd_div_held", 32'(clk_div), 3);
    wait_fall();
    chk("upd_cur_period", fall_at - f0, 16);
    f1 = fall_at;
    wait_fall();
    chk("upd_next_period", fall_at - f1, 8);

    // update exactly on the 3->0 edge applies immediately
    i = 0;
    while (!(m_ph == 3 && m_cnt == m_div) && i < 40) begin step(); i++; end
    chk("bnd_ph", 32'(phase_o), 3);
    set_clk_div = 8'd2; div_update = 1'b1;
    step();
    div_update = 1'b0;
    chk("bnd_applied", 32'(clk_div), 2);
    chk("bnd_no_pend", 32'(div_pending), 0);
    chk("bnd_fall", 32'(fall_o), 1);
    repeat (6) step();

    // disable from phase 3: clk_o drops without fall_o
    i = 0;
    while (phase_o != 2'd3 && i < 40) begin step(); i++; end
    chk("dis_ph3", 32'(clk_o), 1);
    clk_en = 1'b0;
    step();
    chk("dis_clk", 32'(clk_o), 0);
    chk("dis_fall", 32'(fall_o), 0);
    chk("dis_phase", 32'(phase_o), 0);

    // reset mid-phase 2 clears outputs without a clock edge
    clk_en = 1'b1;
    wait_rise();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_outs", {26'd0, div_pending, clk_o, phase_o, tick_o, rise_o, fall_o}, 0);
    chk("arst_div", 32'(clk_div), RD);
    rst_n = 1'b1;
    cyc = 0; rise_at = 0;
    repeat (30) step();
    chk("post_rst_rise", rise_at, 12);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=0 exp=1");
    $fatal(1);
  end
endmodule
